store_buffer: RTL and testbench

- Small in-order FIFO of pending stores between the MEM stage and data_ram.
- Accepts stores from the pipeline in one cycle, then drains them to data_ram one per cycle whenever the single RAM port is not needed by a load.
- Detects load/store byte overlap and stalls the load until the conflicting store has retired, so loads always observe program order.

---
 rtl/rv_mem_pkg.sv | 39 +++
 rtl/load_extract.sv | 26 ++
 rtl/store_buffer.sv | 160 ++++++++++++++++
 tb/tb_store_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared memory-access definitions: funct3 encodings, byte-lane helpers and
// the store-buffer entry layout used by store_buffer and load_extract.
package rv_mem_pkg;

  localparam int unsigned MEM_AW = 32;
  localparam int unsigned XLEN   = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [MEM_AW-3:0] word;
    logic [1:0]        off;
    logic [XLEN-1:0]   wdata;
    logic [2:0]        funct3;
    logic [3:0]        mask;
  } stb_entry_t;

  // Byte lanes touched by an access; loads and stores share the encoding.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: byte_mask = 4'b0001 << off;
      F3_H, F3_HU: byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default:     byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: is_misaligned = off[0];
      F3_W:        is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Load byte-lane select with sign/zero extension per funct3 and address offset.
module load_extract
  import rv_mem_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*off_i +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between MEM and data_ram with load-overlap stalling.
// Define STB_FWD_EN to forward loads fully covered by the youngest SW.
module store_buffer
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [AW-1:0]   st_addr,
  input  logic [31:0]     st_wdata,
  input  logic [2:0]      st_funct3,
  output logic            st_misalign,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_addr,
  input  logic [2:0]      ld_funct3,
  output logic            ld_stall,
  output logic            ld_fwd_valid,
  output logic [31:0]     ld_fwd_data,
  output logic            ram_wen,
  output logic [AW-1:0]   ram_addr,
  output logic [31:0]     ram_wdata,
  output logic [2:0]      ram_funct3,
  output logic            empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          st_misalign_q, st_misalign_d;
  stb_entry_t    mem_q [DEPTH];

  logic              full;
  logic              st_mis_c;
  logic              enq;
  logic              deq;
  logic              conflict;
  logic              ld_owns_port;
  logic [3:0]        ld_mask;
  logic [MEM_AW-3:0] ld_word;
  logic [PW-1:0]     idx;
  stb_entry_t        new_entry;
  stb_entry_t        head;

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign st_ready    = !full;
  assign st_misalign = st_misalign_q;
  assign st_mis_c    = is_misaligned(st_funct3, st_addr[1:0]);
  assign enq         = st_valid && !full && !st_mis_c;
  assign ld_mask     = byte_mask(ld_funct3, ld_addr[1:0]);
  assign ld_word     = (MEM_AW-2)'(ld_addr[AW-1:2]);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    new_entry.word   = (MEM_AW-2)'(st_addr[AW-1:2]);
    new_entry.off    = st_addr[1:0];
    new_entry.wdata  = st_wdata;
    new_entry.funct3 = st_funct3;
    new_entry.mask   = byte_mask(st_funct3, st_addr[1:0]);
  end

`ifdef STB_FWD_EN
  logic        yng_is_sw;
  logic [31:0] yng_wdata;
  logic [31:0] fwd_data;
`endif

  // Scan oldest to youngest so the last hit is the youngest overlapping entry.
  always_comb begin
    conflict = 1'b0;
    idx      = '0;
`ifdef STB_FWD_EN
    yng_is_sw = 1'b0;
    yng_wdata = '0;
`endif
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (mem_q[idx].word == ld_word) &&
          ((mem_q[idx].mask & ld_mask) != 4'b0000)) begin
        conflict = 1'b1;
`ifdef STB_FWD_EN
        yng_is_sw = (mem_q[idx].funct3 == F3_W);
        yng_wdata = mem_q[idx].wdata;
`endif
      end
    end
  end

`ifdef STB_FWD_EN
  load_extract u_load_extract (
    .word_i   (yng_wdata),
    .off_i    (ld_addr[1:0]),
    .funct3_i (ld_funct3),
    .data_o   (fwd_data)
  );

  assign ld_fwd_valid = ld_valid && conflict && yng_is_sw;
  assign ld_fwd_data  = ld_fwd_valid ? fwd_data : 32'b0;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'b0;
`endif

  // A forwarded or stalled load leaves the RAM port to the drain.
  assign ld_stall     = ld_valid && conflict && !ld_fwd_valid;
  assign ld_owns_port = ld_valid && !ld_stall && !ld_fwd_valid;
  assign ram_wen      = !empty && !ld_owns_port;
  assign deq          = ram_wen;
  assign ram_wdata    = head.wdata;
  assign ram_addr     = ld_owns_port ? ld_addr : {(AW-2)'(head.word), head.off};
  assign ram_funct3   = ld_owns_port ? ld_funct3 : head.funct3;

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    st_misalign_d = st_valid && !full && st_mis_c;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      st_misalign_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      st_misalign_q <= st_misalign_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected RAM writes are queued at enqueue
// and checked in order as the DUT drains them.
module tb_store_buffer;
  import rv_mem_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [2:0]    st_funct3;
  logic          st_misalign;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_funct3;
  logic          ld_stall;
  logic          ld_fwd_valid;
  logic [31:0]   ld_fwd_data;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [2:0]    ram_funct3;
  logic          empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .st_funct3    (st_funct3),
    .st_misalign  (st_misalign),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_funct3    (ld_funct3),
    .ld_stall     (ld_stall),
    .ld_fwd_valid (ld_fwd_valid),
    .ld_fwd_data  (ld_fwd_data),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_funct3   (ram_funct3),
    .empty        (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every RAM write must match the oldest outstanding expected store.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && ram_wen) begin
      if (sb_q.size() == 0) begin
        check("wr_unexpected", 32'(ram_wen), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", ram_addr, e.addr);
        check("wr_data", ram_wdata, e.data);
        check("wr_f3", 32'(ram_funct3), 32'(e.f3));
      end
    end
  end

  task automatic offer_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f3, output logic rdy);
    logic mis;
    mis = ((f3 == F3_H) && a[0]) || ((f3 == F3_W) && (a[1:0] != 2'b00));
    st_valid  = 1'b1;
    st_addr   = a;
    st_wdata  = d;
    st_funct3 = f3;
    @(negedge clk);
    rdy = st_ready;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    if (rdy && !mis) sb_q.push_back('{a, d, f3});
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!empty && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 32'(empty), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic rdy;
    rst       = 1'b1;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_wdata  = '0;
    st_funct3 = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_funct3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_misalign", 32'(st_misalign), 32'd0);
    check("rst_stall", 32'(ld_stall), 32'd0);
    check("rst_fwd", 32'(ld_fwd_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single SW drains the following cycle.
    offer_store(32'h100, 32'hDEADBEEF, F3_W, rdy);
    check("sw_rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    check("sw_wen", 32'(ram_wen), 32'd1);
    @(posedge clk);
    #1;
    check("sw_empty", 32'(empty), 32'd1);

    // Fill with loads holding the port, then drain in order.
    ld_valid  = 1'b1;
    ld_addr   = 32'h900;
    ld_funct3 = F3_W;
    for (int i = 0; i < 4; i++) begin
      offer_store(32'h200 + 32'(i), 32'hA0 + 32'(i), F3_B, rdy);
      check("fill_rdy", 32'(rdy), 32'd1);
    end
    st_valid  = 1'b1;
    st_addr   = 32'h204;
    st_wdata  = 32'hA4;
    st_funct3 = F3_B;
    @(negedge clk);
    check("full_ready", 32'(st_ready), 32'd0);
    check("full_wen", 32'(ram_wen), 32'd0);
    check("full_ldaddr", ram_addr, 32'h900);
    check("full_stall", 32'(ld_stall), 32'd0);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    wait_empty(20);

    // SH then overlapping LBU stalls for exactly the drain cycle.
    offer_store(32'h300, 32'h0000ABCD, F3_H, rdy);
    ld_valid  = 1'b1;
    ld_addr   = 32'h301;
    ld_funct3 = F3_BU;
    @(negedge clk);
    check("ovl_stall", 32'(ld_stall), 32'd1);
    check("ovl_wen", 32'(ram_wen), 32'd1);
    check("ovl_fwd", 32'(ld_fwd_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ovl_unstall", 32'(ld_stall), 32'd0);
    check("ovl_ldport", ram_addr, 32'h301);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;

    // SH to low half does not conflict with LBU of byte 2.
    offer_store(32'h300, 32'h00001234, F3_H, rdy);
    ld_valid  = 1'b1;
    ld_addr   = 32'h302;
    ld_funct3 = F3_BU;
    @(negedge clk);
    check("noovl_stall", 32'(ld_stall), 32'd0);
    check("noovl_wen", 32'(ram_wen), 32'd0);
    check("noovl_addr", ram_addr, 32'h302);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    wait_empty(10);

    // Misaligned SW and SH are dropped with a one-cycle pulse.
    for (int i = 0; i < 2; i++) begin
      if (i == 0) offer_store(32'h402, 32'h11111111, F3_W, rdy);
      else        offer_store(32'h401, 32'h22222222, F3_H, rdy);
      check("mis_rdy", 32'(rdy), 32'd1);
      @(negedge clk);
      check("mis_pulse", 32'(st_misalign), 32'd1);
      check("mis_empty", 32'(empty), 32'd1);
      check("mis_wen", 32'(ram_wen), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mis_clear", 32'(st_misalign), 32'd0);
      @(posedge clk);
      #1;
    end

    // Reset with three pending stores discards them.
    ld_valid  = 1'b1;
    ld_addr   = 32'h900;
    ld_funct3 = F3_W;
    for (int i = 0; i < 3; i++) begin
      offer_store(32'h600 + 32'(4 * i), 32'hC0DE0000 + 32'(i), F3_W, rdy);
      check("pend_rdy", 32'(rdy), 32'd1);
    end
    check("pend_notempty", 32'(empty), 32'd0);
    ld_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_wen", 32'(ram_wen), 32'd0);
    check("mrst_ready", 32'(st_ready), 32'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mrst_still_empty", 32'(empty), 32'd1);

    // SW 0x500 then LB 0x501 and LW 0x500 against the pending entry.
    ld_valid  = 1'b1;
    ld_addr   = 32'h900;
    ld_funct3 = F3_W;
    offer_store(32'h500, 32'h000080FF, F3_W, rdy);
    ld_addr   = 32'h501;
    ld_funct3 = F3_B;
    #1;
`ifdef STB_FWD_EN
    check("fwd_lb_valid", 32'(ld_fwd_valid), 32'd1);
    check("fwd_lb_data", ld_fwd_data, 32'hFFFFFF80);
    check("fwd_lb_stall", 32'(ld_stall), 32'd0);
    check("fwd_lb_wen", 32'(ram_wen), 32'd1);
    ld_addr   = 32'h500;
    ld_funct3 = F3_W;
    #1;
    check("fwd_lw_valid", 32'(ld_fwd_valid), 32'd1);
    check("fwd_lw_data", ld_fwd_data, 32'h000080FF);
`else
    check("nofwd_stall", 32'(ld_stall), 32'd1);
    check("nofwd_valid", 32'(ld_fwd_valid), 32'd0);
    check("nofwd_data", ld_fwd_data, 32'd0);
    check("nofwd_wen", 32'(ram_wen), 32'd1);
`endif
    @(negedge clk);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    wait_empty(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
